// File: rtl/load_store_unit.sv
// Load/store sequencer: turns one byte/half/word/double request into a single
// aligned 64-bit memory_controller transaction and returns extended load data.
module load_store_unit #(
    parameter int DATA_SIZE = 64,
    parameter int ADDR_SIZE = 64,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [DATA_SIZE-1:0] req_wdata,
    output logic                 resp_valid,
    output logic [DATA_SIZE-1:0] resp_rdata,
    output logic                 resp_misaligned,
    output logic                 resp_timeout,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [7:0]           mem_byte_en,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] wr_data,
    input  logic [DATA_SIZE-1:0] rd_data,
    input  logic                 mem_busy,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    localparam logic [4:0] LAST = 5'(TIMEOUT - 1);

    state_t               state;
    logic [4:0]           cnt;
    logic [2:0]           off_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic                 we_q;
    logic [2:0]           req_off;
    logic                 aligned;
    logic [7:0]           lane_mask;
    logic [DATA_SIZE-1:0] data_mask;
    logic [DATA_SIZE-1:0] rd_shift;
    logic [DATA_SIZE-1:0] rd_ext;

    // Request handshake: a request transfers on a rising edge with
    // req_valid && req_ready; req_ready is high only while IDLE.
    assign req_ready = (state == IDLE);
    assign state_dbg = state;
    assign req_off   = req_addr[2:0];

    always_comb begin
        aligned   = 1'b1;
        lane_mask = 8'h01;
        data_mask = {{(DATA_SIZE-8){1'b0}}, 8'hFF};
        case (req_size)
            2'd1: begin
                aligned   = ~req_off[0];
                lane_mask = 8'h03;
                data_mask = {{(DATA_SIZE-16){1'b0}}, 16'hFFFF};
            end
            2'd2: begin
                aligned   = (req_off[1:0] == 2'b00);
                lane_mask = 8'h0F;
                data_mask = {{(DATA_SIZE-32){1'b0}}, 32'hFFFF_FFFF};
            end
            2'd3: begin
                aligned   = (req_off == 3'b000);
                lane_mask = 8'hFF;
                data_mask = '1;
            end
            default: ;
        endcase
    end

    // Load data is lane-extracted from the captured offset, then extended.
    always_comb begin
        rd_shift = rd_data >> {off_q, 3'b000};
        case (size_q)
            2'd0:    rd_ext = {{(DATA_SIZE-8){~uns_q & rd_shift[7]}}, rd_shift[7:0]};
            2'd1:    rd_ext = {{(DATA_SIZE-16){~uns_q & rd_shift[15]}}, rd_shift[15:0]};
            2'd2:    rd_ext = {{(DATA_SIZE-32){~uns_q & rd_shift[31]}}, rd_shift[31:0]};
            default: rd_ext = rd_shift;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            cnt             <= '0;
            off_q           <= '0;
            size_q          <= '0;
            uns_q           <= 1'b0;
            we_q            <= 1'b0;
            mem_rd_en       <= 1'b0;
            mem_wr_en       <= 1'b0;
            mem_byte_en     <= '0;
            mem_addr        <= '0;
            wr_data         <= '0;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            resp_timeout    <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q  <= req_off;
                        size_q <= req_size;
                        uns_q  <= req_unsigned;
                        we_q   <= req_we;
                        cnt    <= '0;
                        if (aligned) begin
                            state       <= REQ;
                            mem_rd_en   <= ~req_we;
                            mem_wr_en   <= req_we;
                            mem_byte_en <= lane_mask << req_off;
                            mem_addr    <= {req_addr[ADDR_SIZE-1:3], 3'b000};
                            wr_data     <= (req_wdata & data_mask) << {req_off, 3'b000};
                        end else begin
                            state           <= RESP;
                            resp_valid      <= 1'b1;
                            resp_rdata      <= '0;
                            resp_misaligned <= 1'b1;
                            resp_timeout    <= 1'b0;
                        end
                    end
                end
                REQ: begin
                    if (mem_busy) begin
                        state <= WAIT;
                    end else if (cnt == LAST) begin
                        state           <= RESP;
                        mem_rd_en       <= 1'b0;
                        mem_wr_en       <= 1'b0;
                        mem_byte_en     <= '0;
                        resp_valid      <= 1'b1;
                        resp_rdata      <= '0;
                        resp_misaligned <= 1'b0;
                        resp_timeout    <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                WAIT: begin
                    if (!mem_busy) begin
                        state           <= RESP;
                        mem_rd_en       <= 1'b0;
                        mem_wr_en       <= 1'b0;
                        mem_byte_en     <= '0;
                        resp_valid      <= 1'b1;
                        resp_rdata      <= we_q ? '0 : rd_ext;
                        resp_misaligned <= 1'b0;
                        resp_timeout    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: memory_controller model plus a
// byte-addressed reference memory used to predict every response.
module tb_load_store_unit;
  localparam int TIMEOUT = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [63:0] req_addr = 64'h0;
  logic [63:0] req_wdata = 64'h0;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_timeout;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [7:0]  mem_byte_en;
  logic [63:0] mem_addr;
  logic [63:0] wr_data;
  logic [63:0] rd_data;
  logic        mem_busy;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad = 0;

  // mode 0: modelled controller, 1: busy never rises, 2: busy driven by the test
  int   mode = 0;
  int   d1 = 0;
  int   d2 = 1;
  logic mdl_busy;
  logic man_busy = 1'b0;
  assign mem_busy = (mode == 2) ? man_busy : mdl_busy;

  logic [63:0] mc_mem [logic [63:0]];
  logic [7:0]  ref_mem [logic [63:0]];

  logic        obs_rd, obs_wr, unstable;
  logic [7:0]  obs_be;
  logic [63:0] obs_addr, obs_wdata;

  load_store_unit #(.DATA_SIZE(64), .ADDR_SIZE(64), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_timeout(resp_timeout),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_byte_en(mem_byte_en),
    .mem_addr(mem_addr), .wr_data(wr_data), .rd_data(rd_data),
    .mem_busy(mem_busy), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // memory_controller model: busy rises d1 cycles after a request, stays d2 cycles
  initial begin
    logic [63:0] cur;
    mdl_busy = 1'b0;
    rd_data = 64'h0;
    unstable = 1'b0;
    forever begin
      @(negedge clock);
      if (mode == 0 && reset && (mem_rd_en || mem_wr_en)) begin
        obs_rd = mem_rd_en; obs_wr = mem_wr_en; obs_be = mem_byte_en;
        obs_addr = mem_addr; obs_wdata = wr_data; unstable = 1'b0;
        repeat (d1) @(negedge clock);
        mdl_busy = 1'b1;
        repeat (d2) @(negedge clock);
        if ({mem_rd_en, mem_wr_en, mem_byte_en, mem_addr, wr_data} !==
            {obs_rd, obs_wr, obs_be, obs_addr, obs_wdata}) unstable = 1'b1;
        cur = mc_mem.exists(mem_addr) ? mc_mem[mem_addr] : 64'h0;
        if (mem_wr_en)
          for (int i = 0; i < 8; i++) if (mem_byte_en[i]) cur[8*i +: 8] = wr_data[8*i +: 8];
        mc_mem[mem_addr] = cur;
        rd_data = cur;
        mdl_busy = 1'b0;
        @(negedge clock);
      end
    end
  end

  function automatic logic [7:0] rdbyte(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a, input int n, input bit uns);
    logic [63:0] v = 64'h0;
    for (int i = 0; i < n; i++) v = v | (64'(rdbyte(a + 64'(i))) << (8 * i));
    if (!uns && n < 8 && v[8*n-1]) v = v | (~64'h0 << (8 * n));
    return v;
  endfunction

  task automatic poke(input logic [63:0] a, input logic [63:0] v);
    mc_mem[a] = v;
    for (int i = 0; i < 8; i++) ref_mem[a + 64'(i)] = v[8*i +: 8];
  endtask

  task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rdata, output bit mis, output bit tout,
                        output int lat, output bit en_seen, output bit after_valid);
    @(negedge clock);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0; en_seen = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (mem_rd_en || mem_wr_en) en_seen = 1'b1;
      if (resp_valid) begin lat = n; break; end
    end
    rdata = resp_rdata; mis = resp_misaligned; tout = resp_timeout;
    @(negedge clock);
    after_valid = resp_valid;
  endtask

  logic [63:0] rd;
  bit          mis, tout, en, after;
  int          lat;

  task automatic test_reset;
    #3;
    total++;
    if ({mem_rd_en, mem_wr_en, mem_byte_en, mem_addr, wr_data, resp_valid, resp_rdata,
         resp_misaligned, resp_timeout, req_ready} !== {138'h0, 2'b00, 1'b1}) begin
      bad++;
      $display("FAIL reset_state: rd=%b wr=%b be=%h addr=%h wd=%h rv=%b rdata=%h req_ready=%b, expected all 0 and req_ready=1",
               mem_rd_en, mem_wr_en, mem_byte_en, mem_addr, wr_data, resp_valid, resp_rdata, req_ready);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_load_double;
    poke(64'h0100_0000, 64'h1122334455667788);
    d1 = 1; d2 = 2;
    do_req(1'b0, 2'd3, 1'b0, 64'h0100_0000, 64'h0, rd, mis, tout, lat, en, after);
    total++;
    if ({obs_be, obs_addr, obs_rd, obs_wr} !== {8'hFF, 64'h0100_0000, 1'b1, 1'b0}) begin
      bad++; $display("FAIL ld_double_mem: be=%h addr=%h rd=%b wr=%b, expected be=ff addr=01000000 rd=1 wr=0",
                      obs_be, obs_addr, obs_rd, obs_wr);
    end
    total++;
    if ({rd, lat, after, mis, tout} !== {64'h1122334455667788, 32'd5, 3'b000}) begin
      bad++; $display("FAIL ld_double_resp: rdata=%h lat=%0d after=%b mis=%b tout=%b, expected 1122334455667788 lat=5 single pulse",
                      rd, lat, after, mis, tout);
    end
  endtask

  task automatic test_store_load_byte;
    d1 = 0; d2 = 1;
    do_req(1'b1, 2'd0, 1'b0, 64'h0100_0003, 64'h1234_5678_9ABC_DEA5, rd, mis, tout, lat, en, after);
    ref_mem[64'h0100_0003] = 8'hA5;
    total++;
    if ({obs_be, obs_wdata, obs_wr, rd, lat} !== {8'h08, 64'h0000_0000_A500_0000, 1'b1, 64'h0, 32'd3}) begin
      bad++; $display("FAIL st_byte: be=%h wd=%h wr=%b rdata=%h lat=%0d, expected be=08 wd=00000000a5000000 wr=1 rdata=0 lat=3",
                      obs_be, obs_wdata, obs_wr, rd, lat);
    end
    do_req(1'b0, 2'd0, 1'b0, 64'h0100_0003, 64'h0, rd, mis, tout, lat, en, after);
    total++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFA5) begin
      bad++; $display("FAIL ld_byte_signed: rdata=%h expected ffffffffffffffa5", rd);
    end
    do_req(1'b0, 2'd0, 1'b1, 64'h0100_0003, 64'h0, rd, mis, tout, lat, en, after);
    total++;
    if (rd !== 64'hA5) begin
      bad++; $display("FAIL ld_byte_unsigned: rdata=%h expected a5", rd);
    end
  endtask

  task automatic test_load_word;
    poke(64'h0, 64'h89AB_CDEF_0123_4567);
    d1 = 2; d2 = 1;
    do_req(1'b0, 2'd2, 1'b1, 64'h4, 64'h0, rd, mis, tout, lat, en, after);
    total++;
    if ({obs_be, obs_addr, rd} !== {8'hF0, 64'h0, 64'h0000_0000_89AB_CDEF}) begin
      bad++; $display("FAIL ld_word_unsigned: be=%h addr=%h rdata=%h, expected be=f0 addr=0 rdata=0000000089abcdef",
                      obs_be, obs_addr, rd);
    end
    do_req(1'b0, 2'd2, 1'b0, 64'h4, 64'h0, rd, mis, tout, lat, en, after);
    total++;
    if (rd !== 64'hFFFF_FFFF_89AB_CDEF) begin
      bad++; $display("FAIL ld_word_signed: rdata=%h expected ffffffff89abcdef", rd);
    end
  endtask

  task automatic test_misaligned;
    do_req(1'b0, 2'd1, 1'b0, 64'h0100_0001, 64'h0, rd, mis, tout, lat, en, after);
    total++;
    if ({mis, tout, en, lat, rd} !== {3'b100, 32'd1, 64'h0}) begin
      bad++; $display("FAIL misaligned_half: mis=%b tout=%b en_seen=%b lat=%0d rdata=%h, expected mis=1 tout=0 en_seen=0 lat=1 rdata=0",
                      mis, tout, en, lat, rd);
    end
    do_req(1'b1, 2'd2, 1'b0, 64'h0100_0006, 64'hDEAD_BEEF, rd, mis, tout, lat, en, after);
    total++;
    if ({mis, tout, en, lat} !== {3'b100, 32'd1}) begin
      bad++; $display("FAIL misaligned_word: mis=%b tout=%b en_seen=%b lat=%0d, expected mis=1 tout=0 en_seen=0 lat=1",
                      mis, tout, en, lat);
    end
  endtask

  task automatic test_timeout;
    mode = 1;
    do_req(1'b0, 2'd3, 1'b0, 64'h0100_0010, 64'h0, rd, mis, tout, lat, en, after);
    total++;
    if ({tout, mis, en, lat, rd, after} !== {3'b101, 32'(TIMEOUT + 1), 64'h0, 1'b0}) begin
      bad++; $display("FAIL timeout: tout=%b mis=%b en_seen=%b lat=%0d rdata=%h after=%b, expected tout=1 mis=0 en_seen=1 lat=%0d rdata=0",
                      tout, mis, en, lat, rd, after, TIMEOUT + 1);
    end
    total++;
    if ({mem_rd_en, mem_wr_en, req_ready} !== 3'b001) begin
      bad++; $display("FAIL timeout_idle: rd=%b wr=%b req_ready=%b, expected 0 0 1", mem_rd_en, mem_wr_en, req_ready);
    end
    mode = 0;
  endtask

  task automatic test_reset_mid;
    mode = 2; man_busy = 1'b0;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h0100_0008;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    man_busy = 1'b1;
    repeat (3) @(negedge clock);
    total++;
    if ({mem_rd_en, req_ready} !== 2'b10) begin
      bad++; $display("FAIL mid_busy_hold: rd=%b req_ready=%b, expected rd=1 req_ready=0", mem_rd_en, req_ready);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({mem_rd_en, mem_wr_en, mem_byte_en, mem_addr, wr_data, resp_valid, resp_rdata,
         resp_misaligned, resp_timeout, req_ready} !== {138'h0, 2'b00, 1'b1}) begin
      bad++; $display("FAIL reset_mid: rd=%b be=%h addr=%h rv=%b req_ready=%b, expected all 0 and req_ready=1",
                      mem_rd_en, mem_byte_en, mem_addr, resp_valid, req_ready);
    end
    @(negedge clock);
    reset = 1'b1; man_busy = 1'b0; mode = 0;
    poke(64'h0100_0008, 64'hCAFE_F00D_0BAD_BEEF);
    d1 = 1; d2 = 1;
    do_req(1'b0, 2'd3, 1'b0, 64'h0100_0008, 64'h0, rd, mis, tout, lat, en, after);
    total++;
    if ({rd, lat, mis, tout} !== {64'hCAFE_F00D_0BAD_BEEF, 32'd4, 2'b00}) begin
      bad++; $display("FAIL after_reset_load: rdata=%h lat=%0d, expected cafef00d0badbeef lat=4", rd, lat);
    end
  endtask

  task automatic test_back_to_back;
    int pulses[$];
    logic [63:0] exp_rd;
    poke(64'h0100_0020, 64'h0F1E_2D3C_4B5A_6978);
    exp_rd = ref_load(64'h0100_0020, 8, 1'b0);
    d1 = 0; d2 = 1;
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h0100_0020;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clock);
      if (resp_valid) begin
        pulses.push_back(c);
        total++;
        if (resp_rdata !== exp_rd) begin
          bad++; $display("FAIL b2b_rdata: rdata=%h expected %h", resp_rdata, exp_rd);
        end
      end
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clock);
    total++;
    if (pulses.size() != 6 || pulses[0] != 3) begin
      bad++; $display("FAIL b2b_count: pulses=%0d first=%0d, expected 6 pulses first at 3",
                      pulses.size(), (pulses.size() > 0) ? pulses[0] : -1);
    end
    for (int i = 1; i < pulses.size(); i++) begin
      total++;
      if (pulses[i] - pulses[i-1] != 4) begin
        bad++; $display("FAIL b2b_spacing: gap=%0d expected 4", pulses[i] - pulses[i-1]);
      end
    end
  endtask

  task automatic test_random;
    for (int t = 0; t < 40; t++) begin
      bit          we, uns, ok;
      logic [1:0]  size;
      logic [63:0] addr, wdata, exp_rd, exp_wd;
      logic [7:0]  exp_be;
      int          n, off, exp_lat;
      we = 1'($urandom_range(0, 1)); uns = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = 64'h0100_0100 + 64'($urandom_range(0, 31));
      wdata = {$urandom, $urandom};
      d1 = $urandom_range(0, 3); d2 = $urandom_range(1, 3);
      n = 1 << size; off = int'(addr[2:0]);
      ok = (off % n) == 0;
      exp_be = 8'h0; exp_wd = 64'h0;
      for (int i = 0; i < n && ok; i++) begin
        exp_be[off + i] = 1'b1;
        exp_wd[8*(off + i) +: 8] = wdata[8*i +: 8];
      end
      exp_rd = (ok && !we) ? ref_load(addr, n, uns) : 64'h0;
      exp_lat = ok ? d1 + d2 + 2 : 1;
      do_req(we, size, uns, addr, wdata, rd, mis, tout, lat, en, after);
      total++;
      if ({lat, mis, tout, rd, en, after} !== {exp_lat, !ok, 1'b0, exp_rd, ok, 1'b0}) begin
        bad++; $display("FAIL rand_resp[%0d]: lat=%0d mis=%b tout=%b rdata=%h en=%b after=%b, expected lat=%0d mis=%b rdata=%h en=%b",
                        t, lat, mis, tout, rd, en, after, exp_lat, !ok, exp_rd, ok);
      end
      if (ok) begin
        total++;
        if ({obs_be, obs_addr, obs_wdata, obs_rd, obs_wr, unstable} !==
            {exp_be, addr & ~64'h7, exp_wd, !we, we, 1'b0}) begin
          bad++; $display("FAIL rand_mem[%0d]: be=%h addr=%h wd=%h rd=%b wr=%b unstable=%b, expected be=%h addr=%h wd=%h",
                          t, obs_be, obs_addr, obs_wdata, obs_rd, obs_wr, unstable, exp_be, addr & ~64'h7, exp_wd);
        end
        if (we) for (int i = 0; i < n; i++) ref_mem[addr + 64'(i)] = wdata[8*i +: 8];
      end
    end
  endtask

  initial begin
    test_reset;
    test_load_double;
    test_store_load_byte;
    test_load_word;
    test_misaligned;
    test_timeout;
    test_reset_mid;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
